// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - GPU, CPU and VRAM signal bundle for vram_arbiter
interface vram_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) ();
  logic              gpu_re;
  logic [ADDR_W-1:0] gpu_addr;
  logic [DATA_W-1:0] gpu_q;
  logic              cpu_start;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_q;
  logic              cpu_busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_d;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  // Arbiter side
  modport slave (
    input  gpu_re, gpu_addr, cpu_start, cpu_we, cpu_addr, cpu_data, ram_q,
    output gpu_q, cpu_done, cpu_q, cpu_busy, ram_addr, ram_d, ram_we
  );

  // Client / VRAM side
  modport master (
    output gpu_re, gpu_addr, cpu_start, cpu_we, cpu_addr, cpu_data, ram_q,
    input  gpu_q, cpu_done, cpu_q, cpu_busy, ram_addr, ram_d, ram_we
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM sharing, GPU first, CPU writes posted
// Optional saturating statistics counters enabled by VRAM_ARB_STATS_EN.
module vram_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          vga_clk,
  input  logic          nreset,
  vram_arbiter_if.slave bus
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_conflicts,
  output logic [15:0]   stat_fifo_full
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {C_IDLE, C_WFULL, C_RD, C_RCAP, C_DONE} cstate_t;

  cstate_t           state;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              fifo_empty, fifo_full;
  logic              rd_slot, pop, push;
  logic [ADDR_W-1:0] push_addr, head_addr;
  logic [DATA_W-1:0] push_data, head_data;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign {head_addr, head_data} = fifo_mem[rd_ptr];
  assign bus.gpu_q  = bus.ram_q;

  // Slot mux: GPU, then a pending CPU read once the FIFO has drained, then FIFO head
  always_comb begin
    rd_slot      = 1'b0;
    pop          = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_addr = bus.gpu_addr;
    bus.ram_d    = head_data;
    if (!bus.gpu_re) begin
      if (state == C_RD && fifo_empty) begin
        rd_slot      = 1'b1;
        bus.ram_addr = lat_addr;
      end else if (!fifo_empty) begin
        pop          = 1'b1;
        bus.ram_we   = 1'b1;
        bus.ram_addr = head_addr;
      end
    end
  end

  always_comb begin
    push      = 1'b0;
    push_addr = bus.cpu_addr;
    push_data = bus.cpu_data;
    if (state == C_IDLE && bus.cpu_start && bus.cpu_we && !fifo_full) begin
      push = 1'b1;
    end else if (state == C_WFULL && !fifo_full) begin
      push      = 1'b1;
      push_addr = lat_addr;
      push_data = lat_data;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (push) fifo_mem[wr_ptr] <= {push_addr, push_data};
  end

  always_ff @(posedge vga_clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge nreset) begin
    if (!nreset) begin
      state        <= C_IDLE;
      lat_addr     <= '0;
      lat_data     <= '0;
      bus.cpu_done <= 1'b0;
      bus.cpu_busy <= 1'b0;
      bus.cpu_q    <= '0;
    end else begin
      bus.cpu_done <= 1'b0;
      case (state)
        C_IDLE: begin
          if (bus.cpu_start) begin
            lat_addr     <= bus.cpu_addr;
            lat_data     <= bus.cpu_data;
            bus.cpu_busy <= 1'b1;
            if (!bus.cpu_we)    state <= C_RD;
            else if (fifo_full) state <= C_WFULL;
            else                state <= C_DONE;
          end
        end
        C_WFULL: if (!fifo_full) state <= C_DONE;
        C_RD:    if (rd_slot) state <= C_RCAP;
        C_RCAP: begin
          bus.cpu_q <= bus.ram_q;
          state     <= C_DONE;
        end
        C_DONE: begin
          bus.cpu_done <= 1'b1;
          bus.cpu_busy <= 1'b0;
          state        <= C_IDLE;
        end
        default: state <= C_IDLE;
      endcase
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge vga_clk or negedge nreset) begin
    if (!nreset) begin
      stat_conflicts <= '0;
      stat_fifo_full <= '0;
    end else begin
      if (bus.gpu_re && (!fifo_empty || state == C_RD) && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
      if (state == C_WFULL && stat_fifo_full != 16'hFFFF)
        stat_fifo_full <= stat_fifo_full + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - random and directed checks of vram_arbiter against a queue-based model
module tb_vram_arbiter;
  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NEVER = 32'h7fff_ffff;

  logic vga_clk = 1'b0;
  logic nreset  = 1'b0;
  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stat_conflicts, stat_fifo_full;
`endif

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .vga_clk(vga_clk),
    .nreset (nreset),
    .bus    (bus)
`ifdef VRAM_ARB_STATS_EN
    ,
    .stat_conflicts(stat_conflicts),
    .stat_fifo_full(stat_fifo_full)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // VRAM with one-cycle read latency; every write is logged
  bit   [DW-1:0]    vram [0:(1<<AW)-1];
  logic [AW+DW-1:0] wr_log [$];
  logic             tb_pre_we = 1'b0;
  logic [AW-1:0]    tb_pre_addr = '0;
  logic [DW-1:0]    tb_pre_data = '0;

  always @(posedge vga_clk) begin
    bus.ram_q <= vram[bus.ram_addr];
    if (tb_pre_we) vram[tb_pre_addr] <= tb_pre_data;
    else if (bus.ram_we) begin
      vram[bus.ram_addr] <= bus.ram_d;
      wr_log.push_back({bus.ram_addr, bus.ram_d});
    end
  end

  // Reference model: posted-write queue, RAM image, CPU-visible memory image
  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} ent_t;
  ent_t          mq [$];
  bit   [DW-1:0] refmem [0:(1<<AW)-1];
  bit   [DW-1:0] shadow [0:(1<<AW)-1];
  int            cyc = 0, m_acc = 0, m_done_at = NEVER;
  bit            m_have = 0, m_wait_push = 0, m_wait_rd = 0, m_is_rd = 0, prev_gpu = 0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_pdata, m_rdata, prev_gpu_data;
`ifdef VRAM_ARB_STATS_EN
  int m_conf = 0, m_ff = 0;
`endif

  initial begin : model
    int            cnt0;
    bit            issue, e_we, busy_e, done_e, idle;
    logic [AW-1:0] e_addr;
    ent_t          ne;
    forever begin
      @(negedge vga_clk);
      cyc++;
      if (tb_pre_we) begin
        refmem[tb_pre_addr] = tb_pre_data;
        shadow[tb_pre_addr] = tb_pre_data;
      end
      if (!nreset) begin
        mq.delete();
        m_have = 0; m_wait_push = 0; m_wait_rd = 0; prev_gpu = 0;
        for (int i = 0; i < (1 << AW); i++) shadow[i] = refmem[i];
        check("rst_busy", bus.cpu_busy, 0);
        check("rst_done", bus.cpu_done, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_cpu_q", bus.cpu_q, 0);
`ifdef VRAM_ARB_STATS_EN
        m_conf = 0; m_ff = 0;
        check("rst_stat_conf", stat_conflicts, 0);
        check("rst_stat_ff", stat_fifo_full, 0);
`endif
      end else begin
        cnt0   = mq.size();
        issue  = 0;
        e_we   = 0;
        e_addr = bus.gpu_addr;
        if (!bus.gpu_re) begin
          if (m_wait_rd && cyc > m_acc && cnt0 == 0) begin
            issue  = 1;
            e_addr = m_addr;
          end else if (cnt0 != 0) begin
            e_we   = 1;
            e_addr = mq[0].addr;
          end
        end
        busy_e = m_have && cyc > m_acc && cyc < m_done_at;
        done_e = m_have && cyc == m_done_at;
        check("ram_we", bus.ram_we, e_we);
        check("ram_addr", bus.ram_addr, e_addr);
        if (e_we) check("ram_d", bus.ram_d, mq[0].data);
        check("cpu_busy", bus.cpu_busy, busy_e);
        check("cpu_done", bus.cpu_done, done_e);
        if (done_e && m_is_rd) check("cpu_q", bus.cpu_q, m_rdata);
        if (prev_gpu) check("gpu_q", bus.gpu_q, prev_gpu_data);
`ifdef VRAM_ARB_STATS_EN
        check("stat_conflicts", stat_conflicts, m_conf);
        check("stat_fifo_full", stat_fifo_full, m_ff);
        if (bus.gpu_re && (cnt0 != 0 || (m_wait_rd && cyc > m_acc)) && m_conf < 65535) m_conf++;
        if (m_wait_push && m_ff < 65535) m_ff++;
`endif
        prev_gpu      = bus.gpu_re;
        prev_gpu_data = refmem[bus.gpu_addr];
        if (e_we) begin
          refmem[mq[0].addr] = mq[0].data;
          void'(mq.pop_front());
        end
        if (issue) begin
          m_wait_rd = 0;
          m_done_at = cyc + 3;
        end
        if (m_wait_push && cnt0 < DEPTH) begin
          ne.addr = m_addr; ne.data = m_pdata;
          mq.push_back(ne);
          m_wait_push = 0;
          m_done_at   = cyc + 2;
        end
        idle = !m_have || cyc >= m_done_at;
        if (bus.cpu_start && idle) begin
          m_have = 1; m_acc = cyc; m_done_at = NEVER;
          m_addr = bus.cpu_addr; m_is_rd = !bus.cpu_we;
          if (bus.cpu_we) begin
            shadow[bus.cpu_addr] = bus.cpu_data;
            if (cnt0 < DEPTH) begin
              ne.addr = bus.cpu_addr; ne.data = bus.cpu_data;
              mq.push_back(ne);
              m_done_at = cyc + 2;
            end else begin
              m_wait_push = 1;
              m_pdata     = bus.cpu_data;
            end
          end else begin
            m_wait_rd = 1;
            m_rdata   = shadow[bus.cpu_addr];
          end
        end
      end
    end
  end

  bit toggle_en = 0;

  task automatic tick();
    @(posedge vga_clk);
    #1;
    if (toggle_en) bus.gpu_re = ~bus.gpu_re;
  endtask

  task automatic start_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_start = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_data = d;
    tick();
    bus.cpu_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.cpu_done && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  initial begin : stim
    int lat, base, n, mode;
    bus.gpu_re = 0; bus.gpu_addr = '0; bus.cpu_start = 0; bus.cpu_we = 0;
    bus.cpu_addr = '0; bus.cpu_data = '0;
    tb_pre_we = 1; tb_pre_addr = 14'h0010; tb_pre_data = 32'hDEADBEEF;
    tick();
    tick();
    tb_pre_we = 0;
    tick();
    check("t0_busy", bus.cpu_busy, 0);
    check("t0_done", bus.cpu_done, 0);
    check("t0_cpu_q", bus.cpu_q, 0);
    check("t0_ram_we", bus.ram_we, 0);
    nreset = 1;
    tick();

    // GPU fetch passes straight through
    bus.gpu_re = 1; bus.gpu_addr = 14'h0010;
    #1;
    check("t1_ram_addr", bus.ram_addr, 14'h0010);
    check("t1_ram_we", bus.ram_we, 0);
    check("t1_busy", bus.cpu_busy, 0);
    tick();
    check("t1_gpu_q", bus.gpu_q, 32'hDEADBEEF);
    tick();
    bus.gpu_re = 0;
    tick();

    // Single posted write, GPU idle
    base = wr_log.size();
    start_op(1, 14'h0100, 32'h12345678);
    wait_done(lat);
    check("t2_latency", lat, 2);
    repeat (3) tick();
    check("t2_nwrites", wr_log.size() - base, 1);
    check("t2_write", wr_log[base], {14'h0100, 32'h12345678});

    // Five writes against a busy GPU; the fifth waits for space
    bus.gpu_re = 1;
    for (int i = 0; i < 4; i++) begin
      start_op(1, AW'(14'h0300 + i), DW'(32'h1000 + i));
      wait_done(lat);
      check("t3_latency", lat, 2);
    end
    start_op(1, 14'h0304, 32'h1004);
    repeat (3) tick();
    check("t3_wfull_busy", bus.cpu_busy, 1);
    base = wr_log.size();
    bus.gpu_re = 0;
    n = 0;
    while (!bus.cpu_done && n < 200) begin
      tick();
      n++;
    end
    check("t3_fifth_done", n, 3);
    repeat (8) tick();
    check("t3_nwrites", wr_log.size() - base, 5);
    for (int i = 0; i < 5; i++)
      check("t3_order", wr_log[base + i][AW+DW-1:DW], 14'h0300 + i);

    // Read-after-write with the GPU toggling
    bus.gpu_re = 1; toggle_en = 1;
    start_op(1, 14'h0200, 32'hA5A5A5A5);
    wait_done(lat);
    start_op(0, 14'h0200, '0);
    wait_done(lat);
    check("t4_cpu_q", bus.cpu_q, 32'hA5A5A5A5);
    toggle_en = 0; bus.gpu_re = 0;
    tick();

    // Reset while a read waits behind two posted writes
    bus.gpu_re = 1;
    start_op(1, 14'h0400, 32'h44440000);
    wait_done(lat);
    start_op(1, 14'h0401, 32'h44440001);
    wait_done(lat);
    start_op(0, 14'h0400, '0);
    tick();
    check("t5_busy_pre", bus.cpu_busy, 1);
    bus.gpu_re = 0;
    #1;
    check("t5_we_pre", bus.ram_we, 1);
    base = wr_log.size();
    nreset = 0;
    #1;
    check("t5_busy_async", bus.cpu_busy, 0);
    check("t5_we_async", bus.ram_we, 0);
    check("t5_cpu_q_async", bus.cpu_q, 0);
    tick();
    nreset = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.cpu_done) n++;
    end
    check("t5_no_writes", wr_log.size() - base, 0);
    check("t5_no_done", n, 0);

`ifdef VRAM_ARB_STATS_EN
    // Ten conflict cycles behind one posted write, then saturation
    bus.gpu_re = 1;
    start_op(1, 14'h0500, 32'h55555555);
    repeat (10) tick();
    bus.gpu_re = 0;
    tick();
    check("st_conflicts_10", stat_conflicts, 10);
    check("st_fifo_full_0", stat_fifo_full, 0);
    repeat (4) tick();
    bus.gpu_re = 1;
    for (int i = 0; i < 4; i++) begin
      start_op(1, AW'(14'h0510 + i), DW'(i));
      wait_done(lat);
    end
    start_op(1, 14'h0514, 32'h5);
    repeat (65600) tick();
    check("st_conflicts_sat", stat_conflicts, 16'hFFFF);
    check("st_fifo_full_sat", stat_fifo_full, 16'hFFFF);
    bus.gpu_re = 0;
    repeat (20) tick();
`endif

    // Random traffic with GPU load phases
    mode = 0;
    for (int k = 0; k < 4000; k++) begin
      if (k % 64 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       bus.gpu_re = ($urandom_range(0, 3) == 0);
        1:       bus.gpu_re = ($urandom_range(0, 9) != 0);
        default: bus.gpu_re = 1'b0;
      endcase
      bus.gpu_addr  = AW'($urandom_range(0, 31));
      bus.cpu_start = ($urandom_range(0, 9) < 4);
      bus.cpu_we    = ($urandom_range(0, 4) < 3);
      bus.cpu_addr  = 14'h0600 | AW'($urandom_range(0, 15));
      bus.cpu_data  = $urandom;
      tick();
    end
    bus.cpu_start = 0;
    bus.gpu_re    = 0;
    repeat (100) tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port VRAM between the GPU pixel-fetch path and the CPU bus. The GPU always has absolute priority.
- CPU writes are posted into a small FIFO and drained into free slots. CPU reads wait for a free slot and for the FIFO to empty.
- Sits between the GPU renderer's vram addr/q pins and the VRAM block, so the renderer's timing is unchanged.

Parameters:
- ADDR_W, 14, VRAM address width.
- DATA_W, 32, VRAM data width.
- FIFO_DEPTH, 4, posted-write FIFO entries (power of two, ≥2).

Ports:
- vga_clk  in  1  system/pixel clock.
- nreset  in  1  async active-low reset.
- gpu_re  in  1  GPU read request this cycle.
- gpu_addr  in  ADDR_W  GPU read address.
- gpu_q  out  DATA_W  GPU read data (= ram_q).
- cpu_start  in  1  CPU access request pulse.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_start.
- cpu_addr  in  ADDR_W  CPU address; sampled with cpu_start.
- cpu_data  in  DATA_W  CPU write data; sampled with cpu_start.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_q  out  DATA_W  CPU read data, valid when cpu_done follows a read.
- cpu_busy  out  1  request in progress.
- ram_addr  out  ADDR_W  VRAM address.
- ram_d  out  DATA_W  VRAM write data.
- ram_we  out  1  VRAM write enable.
- ram_q  in  DATA_W  VRAM read data, 1-cycle latency.

Behaviour:
- Reset (nreset low, async): FIFO empty, CPU FSM = C_IDLE, cpu_done=0, cpu_busy=0, cpu_q=0, ram_we=0. Reset mid-operation drops any pending CPU access and all FIFO contents.
- Slot mux (combinational, each cycle, in priority order):
  - 1) gpu_re=1: ram_addr=gpu_addr, ram_we=0.
  - 2) FSM in C_RD and FIFO empty: ram_addr=CPU read address, ram_we=0.
  - 3) FIFO non-empty: ram_addr/ram_d=FIFO head, ram_we=1, pop.
  - 4) Otherwise: ram_we=0, ram_addr=gpu_addr.
- gpu_q is ram_q, passed through. GPU read latency is exactly that of the RAM (1 cycle); the arbiter adds no delay.
- CPU FSM states: C_IDLE, C_WFULL, C_RD, C_RCAP, C_DONE.
- C_IDLE, cpu_start=1: latch addr/data/we; cpu_busy=1 from the next cycle.
  - Write with FIFO not full → push the same cycle → C_DONE.
  - Write with FIFO full → C_WFULL.
  - Read → C_RD.
- C_WFULL: push in the first cycle the FIFO is not full → C_DONE. A pop and a push in the same cycle are legal; count stays unchanged.
- C_RD: waits until FIFO empty and gpu_re=0, then issues the read → C_RCAP. Reads therefore see all earlier posted writes (read-after-write ordering).
- C_RCAP: cpu_q ← ram_q → C_DONE.
- C_DONE: cpu_done=1 for exactly one cycle, cpu_busy=0 → C_IDLE.
- cpu_start while cpu_busy=1 or in C_DONE is ignored.
- Minimum latencies, cpu_start to cpu_done: write 2 cycles; read 4 cycles with FIFO empty and GPU idle.
- Starvation: the CPU can be blocked for the whole active line. No timeout; the blanking intervals guarantee progress.
- FIFO: circular, pointers wrap at FIFO_DEPTH, count 0..FIFO_DEPTH. A full FIFO never overwrites; an empty FIFO never pops.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- When defined:
  - Adds output stat_conflicts (16 bits), a saturating count of cycles where gpu_re=1 and a CPU access (FIFO non-empty or C_RD) was pending. Holds at 16'hFFFF; cleared by reset.
  - Adds output stat_fifo_full (16 bits), a saturating count of cycles spent in C_WFULL.
- When undefined: both ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then gpu_re=1 with gpu_addr=0x0010 every cycle, RAM preloaded 0x0010=0xDEADBEEF → ram_addr=0x0010, ram_we=0, gpu_q=0xDEADBEEF one cycle later; cpu_busy=0.
- gpu_re=0, CPU write 0x0100←0x12345678 → cpu_done 2 cycles after cpu_start; ram_we=1, ram_addr=0x0100, ram_d=0x12345678 observed exactly once.
- gpu_re held 1, then 5 CPU writes (FIFO_DEPTH=4) → first 4 complete; 5th holds cpu_busy=1 in C_WFULL. gpu_re drops → 5 writes reach the RAM in order; the 5th cpu_done follows the first pop.
- Write 0x0200←0xA5A5A5A5, then immediately read 0x0200, gpu_re toggling 1/0 → cpu_q=0xA5A5A5A5 on cpu_done; no RAM read is issued before the write.
- Reset pulsed low mid-C_RD with 2 FIFO entries → outputs go to reset values asynchronously; no later ram_we=1 and no cpu_done.
- VRAM_ARB_STATS_EN: 10 cycles of gpu_re=1 with one posted write pending → stat_conflicts=10; forced 0xFFFF+ cycles → holds at 0xFFFF.
